bus_arbiter8: RTL and testbench
===============================

Name: bus_arbiter8

Overview:
- Round-robin arbiter that shares one 16-bit output bus among 8 requesters.
- It registers a one-hot grant and a 3-bit select. The select drives an 8-way 16-bit mux that routes the granted requester's data word to Y.
- It sits in front of shared 16-bit resources (memory port, ALU input) so several sources can use them in turn.
- A hold limit stops one requester from keeping the bus while others wait.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the grant while another request is pending. Legal range 1..255.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  8  request per requester; REQ[i] is held high while requester i wants the bus.
- DIN  input  128  packed data words; requester i drives DIN[16*i+15:16*i].
- GNT  output  8  one-hot grant, registered; all-zero when idle.
- SEL  output  3  binary index of the granted requester, registered.
- VALID  output  1  high while a grant is active (GNT != 0).
- Y  output  16  DIN word of the granted requester when VALID=1, else 16'h0000. Combinational from SEL/VALID/DIN.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset (RST=1 at an edge):
  - state=IDLE, GNT=8'h00, SEL=0, VALID=0, Y=16'h0000.
  - Round-robin pointer PTR=0, hold counter HCNT=0.
  - RST overrides all other inputs. Asserting it mid-grant drops the grant on that edge.
- Arbitration function ARB(mask):
  - Searches REQ&mask in order PTR, PTR+1, ..., PTR+7, indices taken mod 8 (7 wraps to 0).
  - Returns the first set index, or "none".
- States: IDLE, GRANT.
- IDLE:
  - GNT=0, VALID=0.
  - If REQ != 0 at an edge, w=ARB(8'hFF): GNT<=1<<w, SEL<=w, PTR<=(w+1) mod 8, HCNT<=0, go to GRANT.
  - Latency: a request seen at edge n gives GNT/VALID high after edge n (one-cycle registered latency).
- GRANT:
  - VALID=1; Y=DIN word SEL.
  - At each edge, let cur=SEL and others=REQ with bit cur cleared.
  - Release (REQ[cur]=0): w=ARB(others).
    - If a winner exists, grant w on this edge (back-to-back, no idle cycle), HCNT<=0, PTR<=w+1.
    - Else go to IDLE with GNT<=0.
  - Timeout (REQ[cur]=1, HCNT==MAX_HOLD-1, others!=0): forced rotation to w=ARB(others) as above. cur loses the grant even though it still requests.
  - Timeout with others==0: keep grant, HCNT<=0 (no forced release when uncontended).
  - Otherwise: keep grant, HCNT<=HCNT+1.
- GNT is always 0 or one-hot. GNT==(1<<SEL) whenever VALID=1.
- A request that drops and re-asserts while not granted simply competes again at the next arbitration. Requests are not latched.
- REQ bits for the current grantee change only the release decision. They never cause a grant change mid-hold except through the release and timeout rules above.
- HCNT width is 8 bits and never exceeds MAX_HOLD-1.
- Fairness: with all 8 requesting continuously and MAX_HOLD=k, each requester is granted k cycles in order 0..7 and the cycle repeats every 8k cycles.

Test Plan:
- Reset then single request:
  - RST=1 for 2 cycles, then REQ=8'h04 and DIN word2=16'hBEEF.
  - Before the next edge: GNT=0, Y=0.
  - One edge later: GNT=8'h04, SEL=2, VALID=1, Y=16'hBEEF.
  - Drop REQ: one edge later GNT=0, VALID=0, Y=16'h0000.
- Round-robin order:
  - From reset, REQ=8'h81, with each requester dropping REQ one cycle after it is granted.
  - Required grant order: 0 then 7.
  - Re-raise both: grant goes to 0 again (PTR wrapped 7->0 after granting 7... i.e. PTR=0 after 7).
- Back-to-back handoff:
  - REQ=8'h06; requester 1 is granted, then REQ[1] drops while REQ[2] stays high.
  - Next edge: GNT=8'h04 with no cycle where VALID=0.
- Hold limit, MAX_HOLD=4:
  - REQ=8'h03 held constant.
  - GNT=8'h01 for exactly 4 cycles, then 8'h02 for 4 cycles, then 8'h01, repeating.
  - Uncontended REQ=8'h01 keeps GNT=8'h01 for more than 20 cycles.
- Reset mid-operation:
  - While GNT=8'h10 with REQ=8'hFF, pulse RST for 1 cycle.
  - Next edge: GNT=0, VALID=0.
  - Following edge: grant goes to requester 0 (PTR reset to 0).
- Random check over 10k cycles with random REQ:
  - GNT is never multi-hot.
  - Y always equals DIN[SEL] when VALID=1.
  - No requester waits more than 7*MAX_HOLD+1 cycles while it holds REQ high.

Source files
------------

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter: 8 requesters share one 16-bit bus, with a hold limit
// that forces rotation when another requester is waiting.
module bus_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   REQ,
    input  logic [127:0] DIN,
    output logic [7:0]   GNT,
    output logic [2:0]   SEL,
    output logic         VALID,
    output logic [15:0]  Y
);

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 3;
    localparam int unsigned HW = 8;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [IW-1:0]   sel_q,   sel_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [HW-1:0]   hcnt_q,  hcnt_d;

    logic [N-1:0]    others;
    logic [IW:0]     win;
    logic            rotate;

    // First set bit of req searching upward from ptr with wrap; MSB = found.
    function automatic logic [IW:0] arb(input logic [N-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + IW'(k);
            if (!res[IW] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state: arbitration, release/timeout handling and hold counting.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        others  = REQ & ~gnt_q;
        win     = '0;
        rotate  = 1'b0;

        case (state_q)
            IDLE: begin
                win    = arb(REQ, ptr_q);
                rotate = win[IW];
            end
            GRANT: begin
                win = arb(others, ptr_q);
                if (!REQ[sel_q]) begin
                    if (win[IW]) begin
                        rotate = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        hcnt_d  = '0;
                    end
                end else if (hcnt_q == HOLD_LAST) begin
                    // Contended: forced rotation; uncontended: restart the hold window.
                    if (win[IW]) begin
                        rotate = 1'b1;
                    end else begin
                        hcnt_d = '0;
                    end
                end else begin
                    hcnt_d = HW'(hcnt_q + HW'(1));
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        if (rotate) begin
            state_d = GRANT;
            gnt_d   = N'(1) << win[IW-1:0];
            sel_d   = win[IW-1:0];
            valid_d = 1'b1;
            ptr_d   = IW'(win[IW-1:0] + IW'(1));
            hcnt_d  = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign VALID = valid_q;

    // Output mux: granted requester's word, zero when idle.
    always_comb begin
        Y = '0;
        if (valid_q) begin
            Y = DIN[{sel_q, 4'b0000} +: DW];
        end
    end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Bench for bus_arbiter8: directed literal checks plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_bus_arbiter8;

    localparam int MH = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [7:0]   REQ = '0;
    logic [127:0] DIN;
    logic [7:0]   GNT;
    logic [2:0]   SEL;
    logic         VALID;
    logic [15:0]  Y;

    logic [15:0]  din_w [8];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Behavioural model: owner index (-1 = none), next search start, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int waitc [8];

    bus_arbiter8 #(.MAX_HOLD(MH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .DIN   (DIN),
        .GNT   (GNT),
        .SEL   (SEL),
        .VALID (VALID),
        .Y     (Y)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < 8; i++) DIN[16*i +: 16] = din_w[i];
    end

    function automatic int pick(input logic [7:0] m, input int p);
        for (int k = 0; k < 8; k++) begin
            if (m[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        cyc();
        RST = 1'b0;
    endtask

    // Model update on each rising edge from the inputs seen at that edge.
    always @(posedge CLK) begin : model
        logic [7:0] others;
        int w;
        if (RST) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            w = pick(REQ, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_ptr = (w + 1) % 8; m_held = 1;
            end
        end else begin
            others = REQ;
            others[m_owner] = 1'b0;
            if (!REQ[m_owner] || (m_held >= MH && others != 0)) begin
                w = pick(others, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_ptr = (w + 1) % 8; m_held = 1;
                end else begin
                    m_owner = -1; m_held = 0;
                end
            end else if (m_held >= MH) begin
                m_held = 1;
            end else begin
                m_held++;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge CLK) begin : compare
        logic [7:0] exp_gnt;
        bit late;
        if (chk_en) begin
            exp_gnt = (m_owner < 0) ? 8'h00 : (8'(1) << m_owner);
            chk("gnt", 16'(GNT), 16'(exp_gnt));
            chk("valid", 16'(VALID), 16'(m_owner >= 0));
            if (m_owner >= 0) chk("sel", 16'(SEL), 16'(m_owner));
            chk("y", Y, (m_owner >= 0) ? din_w[m_owner] : 16'h0000);
            chk("onehot", 16'($onehot0(GNT)), 16'd1);
            late = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (RST || !REQ[i] || GNT[i]) waitc[i] = 0;
                else waitc[i]++;
                if (waitc[i] > 7 * MH + 1) late = 1'b1;
            end
            chk("starve", 16'(late), 16'd0);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            din_w[i] = 16'h0000;
            waitc[i] = 0;
        end
        for (int i = 0; i < 8; i++) din_w[i] = 16'(16'h1000 * i + 16'h0011 * i);

        // Reset then single request
        RST = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        RST = 1'b0;
        REQ = 8'h04;
        din_w[2] = 16'hBEEF;
        #1;
        chk("pre_gnt", 16'(GNT), 16'h0000);
        chk("pre_y", Y, 16'h0000);
        cyc();
        chk("t1_gnt", 16'(GNT), 16'h0004);
        chk("t1_sel", 16'(SEL), 16'd2);
        chk("t1_valid", 16'(VALID), 16'd1);
        chk("t1_y", Y, 16'hBEEF);
        REQ = 8'h00;
        cyc();
        chk("t1_drop_gnt", 16'(GNT), 16'h0000);
        chk("t1_drop_valid", 16'(VALID), 16'd0);
        chk("t1_drop_y", Y, 16'h0000);

        // Round-robin order with wrap
        do_reset();
        REQ = 8'h81;
        cyc();
        chk("rr_first", 16'(GNT), 16'h0001);
        REQ = 8'h80;
        cyc();
        chk("rr_second", 16'(GNT), 16'h0080);
        REQ = 8'h00;
        cyc();
        REQ = 8'h81;
        cyc();
        chk("rr_wrap", 16'(GNT), 16'h0001);

        // Back-to-back handoff
        do_reset();
        REQ = 8'h06;
        cyc();
        chk("b2b_first", 16'(GNT), 16'h0002);
        REQ = 8'h04;
        cyc();
        chk("b2b_gnt", 16'(GNT), 16'h0004);
        chk("b2b_valid", 16'(VALID), 16'd1);

        // Hold limit alternation, then uncontended hold
        do_reset();
        REQ = 8'h03;
        for (int c = 0; c < 16; c++) begin
            cyc();
            chk("hold_alt", 16'(GNT), ((c / 4) % 2 != 0) ? 16'h0002 : 16'h0001);
        end
        REQ = 8'h01;
        for (int c = 0; c < 25; c++) begin
            cyc();
            chk("hold_solo", 16'(GNT), 16'h0001);
        end

        // Full-load fairness up to requester 4, then reset mid-grant
        do_reset();
        REQ = 8'hFF;
        for (int c = 0; c < 17; c++) begin
            cyc();
            chk("fair", 16'(GNT), 16'(8'(1) << (c / 4)));
        end
        RST = 1'b1;
        cyc();
        chk("rst_gnt", 16'(GNT), 16'h0000);
        chk("rst_valid", 16'(VALID), 16'd0);
        RST = 1'b0;
        cyc();
        chk("rst_ptr", 16'(GNT), 16'h0001);

        // Randomized traffic
        for (int n = 0; n < 10000; n++) begin
            cyc();
            RST = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < 8; i++) begin
                din_w[i] = 16'($urandom);
                if (m_owner == i)  REQ[i] = ($urandom_range(0, 3) != 0);
                else if (REQ[i])   REQ[i] = ($urandom_range(0, 15) != 0);
                else               REQ[i] = ($urandom_range(0, 3) == 0);
            end
        end

        RST = 1'b0;
        REQ = 8'h00;
        cyc();
        cyc();
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
